// File: rtl/paddle_ctrl.sv
// Paddle position controller: button levels become tick-paced motion with a
// hold-to-accelerate ramp, power-up length changes and recentering while idle.
module paddle_ctrl #(
    parameter int SCREEN_W    = 160,
    parameter int X_W         = 8,
    parameter int LEN_INIT    = 32,
    parameter int LEN_MIN     = 16,
    parameter int LEN_MAX     = 48,
    parameter int LEN_STEP    = 8,
    parameter int TICK_DIV    = 250000,
    parameter int ACCEL_TICKS = 8,
    parameter int MAX_SPEED   = 4
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [2:0]     state,
    input  logic           left,
    input  logic           right,
    input  logic           grow,
    input  logic           shrink,
    output logic [X_W-1:0] paddleX,
    output logic [X_W-1:0] paddleLen,
    output logic [2:0]     speed,
    output logic           atLeft,
    output logic           atRight
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 2);

    // One spare bit so move and length arithmetic can never wrap.
    typedef logic [X_W:0] wide_t;

    localparam wide_t SCR   = wide_t'(SCREEN_W);
    localparam wide_t LMIN  = wide_t'(LEN_MIN);
    localparam wide_t LMAX  = wide_t'(LEN_MAX);
    localparam wide_t LSTEP = wide_t'(LEN_STEP);
    localparam wide_t ONE_W = wide_t'(1);

    localparam logic [X_W-1:0]    X_INIT   = X_W'((SCREEN_W - LEN_INIT) / 2);
    localparam logic [X_W-1:0]    L_INIT   = X_W'(LEN_INIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(ACCEL_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [2:0]        SPD_MAX  = 3'(MAX_SPEED);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_e;

    logic [X_W-1:0]    x_q, x_d;
    logic [X_W-1:0]    len_q, len_d;
    logic [2:0]        speed_q, speed_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dir_e              last_q, last_d, dir;

    logic  active, idle, tick;
    wide_t step, len_w, x_move, x_lim;

    assign active = (state == 3'b001) || (state == 3'b010);
    assign idle   = (state == 3'b000);
    assign tick   = active && (cnt_q == CNT_LAST);

    always_comb begin
        if (left && !right)      dir = DIR_L;
        else if (right && !left) dir = DIR_R;
        else                     dir = DIR_NONE;
    end

    always_comb begin
        // NOTE: every variable gets a hold/default value first, so no path can
        // leave one unassigned and infer a latch.
        cnt_d    = cnt_q;
        x_d      = x_q;
        len_d    = len_q;
        speed_d  = speed_q;
        hold_d   = hold_q;
        last_d   = last_q;
        hold_inc = hold_q + HOLD_ONE;
        step     = '0;
        len_w    = wide_t'(len_q);
        x_move   = wide_t'(x_q);
        x_lim    = '0;

        if (idle) begin
            cnt_d   = '0;
            x_d     = X_W'((SCR - wide_t'(len_q)) >> 1);
            speed_d = 3'd1;
            hold_d  = '0;
        end else if (active) begin
            cnt_d = tick ? '0 : cnt_q + CNT_ONE;

            if (grow && !shrink)
                len_w = (wide_t'(len_q) + LSTEP > LMAX) ? LMAX : wide_t'(len_q) + LSTEP;
            else if (shrink && !grow)
                len_w = (wide_t'(len_q) < LMIN + LSTEP) ? LMIN : wide_t'(len_q) - LSTEP;

            if (dir == DIR_NONE) begin
                speed_d = 3'd1;
                hold_d  = '0;
                last_d  = DIR_NONE;
            end else if (tick) begin
                // A reversal or fresh press restarts the ramp at one pixel.
                if (dir != last_q) begin
                    step    = ONE_W;
                    speed_d = 3'd1;
                    hold_d  = HOLD_ONE;
                end else begin
                    step = wide_t'(speed_q);
                    if (hold_inc >= HOLD_LIM) begin
                        hold_d  = '0;
                        speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 3'd1;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                last_d = dir;
                if (dir == DIR_L)
                    x_move = (wide_t'(x_q) >= step) ? wide_t'(x_q) - step : '0;
                else
                    x_move = wide_t'(x_q) + step;
            end

            // Clamp against the new length so growth at the right wall pulls X in.
            x_lim = SCR - len_w;
            x_d   = X_W'((x_move > x_lim) ? x_lim : x_move);
            len_d = X_W'(len_w);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            x_q     <= X_INIT;
            len_q   <= L_INIT;
            speed_q <= 3'd1;
            hold_q  <= '0;
            cnt_q   <= '0;
            last_q  <= DIR_NONE;
        end else begin
            x_q     <= x_d;
            len_q   <= len_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign paddleX   = x_q;
    assign paddleLen = len_q;
    assign speed     = speed_q;
    assign atLeft    = (x_q == '0);
    assign atRight   = (wide_t'(x_q) + wide_t'(len_q) == SCR);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: integer reference model checked every cycle, plus
// directed scenarios with hand-computed positions.
module tb_paddle_ctrl;

    localparam int SCREEN_W  = 160;
    localparam int LEN_INIT  = 32;
    localparam int LEN_MIN   = 16;
    localparam int LEN_MAX   = 48;
    localparam int LEN_STEP  = 8;
    localparam int TICK_DIV  = 4;
    localparam int ACCEL     = 4;
    localparam int MAX_SPEED = 4;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] state  = 3'b000;
    logic       left   = 1'b0;
    logic       right  = 1'b0;
    logic       grow   = 1'b0;
    logic       shrink = 1'b0;
    logic [7:0] paddleX, paddleLen;
    logic [2:0] speed;
    logic       atLeft, atRight;

    int errors = 0;
    int checks = 0;

    paddle_ctrl #(
        .SCREEN_W(SCREEN_W), .X_W(8), .LEN_INIT(LEN_INIT), .LEN_MIN(LEN_MIN),
        .LEN_MAX(LEN_MAX), .LEN_STEP(LEN_STEP), .TICK_DIV(TICK_DIV),
        .ACCEL_TICKS(ACCEL), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clock(clock), .resetn(resetn), .state(state),
        .left(left), .right(right), .grow(grow), .shrink(shrink),
        .paddleX(paddleX), .paddleLen(paddleLen), .speed(speed),
        .atLeft(atLeft), .atRight(atRight)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, direction as -1/0/+1.
    int m_x, m_len, m_speed, m_hold, m_cnt, m_last;
    bit m_valid = 1'b0;

    always @(posedge clock) begin : model
        int  d, nlen, nx, step;
        bit  tk;
        if (!resetn) begin
            m_len = LEN_INIT; m_x = (SCREEN_W - LEN_INIT) / 2;
            m_speed = 1; m_hold = 0; m_cnt = 0; m_last = 0;
            m_valid = 1'b1;
        end else if (state == 3'd0) begin
            m_x = (SCREEN_W - m_len) / 2;
            m_speed = 1; m_hold = 0; m_cnt = 0;
        end else if (state == 3'd1 || state == 3'd2) begin
            tk    = (m_cnt == TICK_DIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            d     = (left && !right) ? -1 : ((right && !left) ? 1 : 0);
            nlen  = m_len;
            if (grow && !shrink)      nlen = (m_len + LEN_STEP > LEN_MAX) ? LEN_MAX : m_len + LEN_STEP;
            else if (shrink && !grow) nlen = (m_len - LEN_STEP < LEN_MIN) ? LEN_MIN : m_len - LEN_STEP;
            nx = m_x;
            if (d == 0) begin
                m_speed = 1; m_hold = 0; m_last = 0;
            end else if (tk) begin
                if (d != m_last) begin
                    step = 1; m_speed = 1; m_hold = 1;
                end else begin
                    step = m_speed;
                    m_hold++;
                    if (m_hold == ACCEL) begin
                        m_hold = 0;
                        m_speed = (m_speed + 1 > MAX_SPEED) ? MAX_SPEED : m_speed + 1;
                    end
                end
                m_last = d;
                nx = m_x + d * step;
                if (nx < 0) nx = 0;
            end
            if (nx > SCREEN_W - nlen) nx = SCREEN_W - nlen;
            m_x = nx; m_len = nlen;
        end else begin
            m_cnt = 0;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_x",     paddleX,   m_x);
            check("model_len",   paddleLen, m_len);
            check("model_speed", speed,     m_speed);
            check("model_atL",   atLeft,    (m_x == 0));
            check("model_atR",   atRight,   (m_x + m_len == SCREEN_W));
        end
    end

    task automatic ticks(input int n);
        repeat (n * TICK_DIV) @(negedge clock);
    endtask

    task automatic pulse(input bit g, input bit s);
        grow = g; shrink = s;
        @(negedge clock);
        grow = 1'b0; shrink = 1'b0;
    endtask

    int exp_right [22] = '{65, 66, 67, 68, 70, 72, 74, 76, 79, 82, 85, 88,
                           92, 96, 100, 104, 108, 112, 116, 120, 124, 128};

    initial begin
        // Reset state.
        resetn = 1'b0;
        @(negedge clock);
        check("rst_x", paddleX, 64);
        check("rst_len", paddleLen, 32);
        check("rst_speed", speed, 1);
        check("rst_atL", atLeft, 0);
        check("rst_atR", atRight, 0);

        // Hold right: accelerating ramp, saturating at the right wall.
        resetn = 1'b1; state = 3'b010; right = 1'b1;
        for (int i = 0; i < 22; i++) begin
            ticks(1);
            check("ramp_x", paddleX, exp_right[i]);
        end
        ticks(3);
        check("wall_x", paddleX, 128);
        check("wall_atR", atRight, 1);
        check("wall_speed", speed, 4);

        // Reversal restarts at one pixel; none and both stop motion.
        right = 1'b0; left = 1'b1;
        ticks(1);
        check("rev_x", paddleX, 127);
        check("rev_speed", speed, 1);
        left = 1'b0;
        ticks(1);
        check("none_x", paddleX, 127);
        check("none_speed", speed, 1);
        left = 1'b1; right = 1'b1;
        ticks(1);
        check("both_x", paddleX, 127);
        right = 1'b0;
        ticks(40);
        check("lwall_x", paddleX, 0);
        check("lwall_atL", atLeft, 1);

        // Walk to X=17, then left run reaching X=2 at speed 3 and clamping to 0.
        left = 1'b0;
        ticks(1);
        right = 1'b1;
        ticks(9);
        check("walk15_x", paddleX, 15);
        right = 1'b0;
        ticks(1);
        right = 1'b1;
        ticks(2);
        check("walk17_x", paddleX, 17);
        right = 1'b0; left = 1'b1;
        ticks(8);
        check("l8_x", paddleX, 5);
        check("l8_speed", speed, 3);
        ticks(1);
        check("l9_x", paddleX, 2);
        check("l9_speed", speed, 3);
        ticks(1);
        check("clamp0_x", paddleX, 0);
        check("clamp0_atL", atLeft, 1);

        // Length changes at the right wall.
        left = 1'b0; right = 1'b1;
        ticks(40);
        check("rw_x", paddleX, 128);
        right = 1'b0;
        @(negedge clock);
        pulse(1'b1, 1'b0);
        check("g1_len", paddleLen, 40);
        check("g1_x", paddleX, 120);
        pulse(1'b1, 1'b0);
        check("g2_len", paddleLen, 48);
        check("g2_x", paddleX, 112);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("g4_len", paddleLen, 48);
        check("g4_x", paddleX, 112);
        pulse(1'b1, 1'b1);
        check("gs_len", paddleLen, 48);
        pulse(1'b0, 1'b1);
        check("s1_len", paddleLen, 40);
        check("s1_x", paddleX, 112);
        check("s1_atR", atRight, 0);

        // Frozen, idle recenter, then reset mid-motion.
        state = 3'b011; right = 1'b1;
        repeat (10) @(negedge clock);
        check("frz_x", paddleX, 112);
        check("frz_len", paddleLen, 40);
        state = 3'b000;
        @(negedge clock);
        check("idle_x", paddleX, 60);
        state = 3'b010;
        repeat (3) @(negedge clock);
        check("first_tick_pre", paddleX, 60);
        @(negedge clock);
        check("first_tick_x", paddleX, 61);
        ticks(2);
        check("pre_rst_x", paddleX, 63);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_rst_x", paddleX, 64);
        check("mid_rst_len", paddleLen, 32);
        check("mid_rst_speed", speed, 1);
        resetn = 1'b1; right = 1'b0; state = 3'b000;
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
